// File: rtl/dsp_block_fetch_if.sv
// Simple start/active read handshake between the block fetcher and the
// Wishbone master interface.
interface dsp_block_fetch_if #(
  parameter int DW = 32,
  parameter int AW = 32
);
  logic          m_start;
  logic [AW-1:0] m_address;
  logic [3:0]    m_selection;
  logic          m_write;
  logic [DW-1:0] m_data_wr;
  logic [DW-1:0] m_data_rd;
  logic          m_active;

  modport master (
    output m_start, m_address, m_selection, m_write, m_data_wr,
    input  m_data_rd, m_active
  );

  modport slave (
    input  m_start, m_address, m_selection, m_write, m_data_wr,
    output m_data_rd, m_active
  );
endinterface

// File: rtl/dsp_block_fetch.sv
// Block read sequencer: fetches cmd_len consecutive words over the master
// start/active handshake and streams them out through a FWFT FIFO.
module dsp_block_fetch #(
  parameter int DW         = 32,
  parameter int AW         = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int LEN_W      = 16,
  parameter int TIMEOUT    = 255
) (
  input  logic                          wb_clk,
  input  logic                          wb_rst,
  input  logic                          cmd_start,
  input  logic [AW-1:0]                 cmd_addr,
  input  logic [LEN_W-1:0]              cmd_len,
  output logic                          cmd_busy,
  output logic                          cmd_done,
  output logic                          cmd_err,
  output logic [LEN_W-1:0]              words_fetched,
  dsp_block_fetch_if.master             m_bus,
  output logic [DW-1:0]                 out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_ISSUE     = 3'd1;
  localparam logic [2:0] S_WAIT_ACT  = 3'd2;
  localparam logic [2:0] S_WAIT_DONE = 3'd3;
  localparam logic [2:0] S_DONE      = 3'd4;
  localparam logic [2:0] S_ABORT     = 3'd5;

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [LVL_W-1:0] DEPTH_L  = LVL_W'(FIFO_DEPTH);

  logic [2:0]          r_state;
  logic [AW-1:0]       r_addr;
  logic [LEN_W-1:0]    r_len;
  logic [LEN_W-1:0]    r_wf;
  logic                r_busy;
  logic                r_done;
  logic                r_err;
  logic                r_m_start;
  logic [AW-1:0]       r_m_addr;
  logic                r_act_q;
  logic [TMO_W-1:0]    r_tmo;

  logic [DW-1:0]       r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [LVL_W-1:0]    r_level;

  logic                w_push;
  logic                w_pop;
  logic                w_reserved;
  logic                w_room;
  logic                w_last;
  logic                w_valid;

  // A word completes when m_active falls while a read is outstanding; a
  // fall seen in any other state (e.g. after reset) is ignored.
  assign w_push     = (r_state == S_WAIT_DONE) && r_act_q && !m_bus.m_active;
  assign w_valid    = (r_level != '0);
  assign w_pop      = w_valid && out_ready;
  assign w_reserved = (r_state == S_WAIT_ACT) || (r_state == S_WAIT_DONE);
  assign w_room     = (r_level + LVL_W'(w_reserved)) < DEPTH_L;
  assign w_last     = (r_wf + LEN_W'(1)) == r_len;

  assign cmd_busy      = r_busy;
  assign cmd_done      = r_done;
  assign cmd_err       = r_err;
  assign words_fetched = r_wf;
  assign out_valid     = w_valid;
  assign out_data      = r_mem[r_rd_ptr];
  assign fifo_level    = r_level;

  assign m_bus.m_start     = r_m_start;
  assign m_bus.m_address   = r_m_addr;
  assign m_bus.m_selection = 4'hF;
  assign m_bus.m_write     = 1'b0;
  assign m_bus.m_data_wr   = {DW{1'b0}};

  // Command sequencer: issue one read at a time, track progress and timeout.
  always_ff @(posedge wb_clk or negedge wb_rst) begin
    if (!wb_rst) begin
      r_state   <= S_IDLE;
      r_addr    <= '0;
      r_len     <= '0;
      r_wf      <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_m_start <= 1'b0;
      r_m_addr  <= '0;
      r_act_q   <= 1'b0;
      r_tmo     <= '0;
    end else begin
      r_act_q   <= m_bus.m_active;
      r_m_start <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cmd_start) begin
            r_addr  <= cmd_addr & ~AW'(3);
            r_len   <= cmd_len;
            r_wf    <= '0;
            r_busy  <= 1'b1;
            r_state <= (cmd_len == '0) ? S_DONE : S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (w_room) begin
            r_m_start <= 1'b1;
            r_m_addr  <= r_addr;
            r_tmo     <= '0;
            r_state   <= S_WAIT_ACT;
          end
        end
        S_WAIT_ACT: begin
          if (m_bus.m_active) begin
            r_state <= S_WAIT_DONE;
          end else if (r_tmo == TMO_LAST) begin
            // Error pulse and busy release coincide with the ABORT cycle.
            r_state <= S_ABORT;
            r_err   <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_tmo <= r_tmo + TMO_W'(1);
          end
        end
        S_WAIT_DONE: begin
          if (w_push) begin
            r_wf    <= r_wf + LEN_W'(1);
            r_addr  <= r_addr + AW'(4);
            r_state <= w_last ? S_DONE : S_ISSUE;
          end
        end
        S_DONE: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        S_ABORT: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // FIFO storage; contents are don't-care until pointed at by a valid entry.
  always_ff @(posedge wb_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= m_bus.m_data_rd;
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop keeps the level.
  always_ff @(posedge wb_clk or negedge wb_rst) begin
    if (!wb_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule
